instr_fetch: RTL and testbench

- Fetch stage of the z0 CPU. Sits directly upstream of the execute units (mov and siblings), which decode instruction[15:8] and instruction[3:0].
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Holds the fetched word in an instruction register and presents it to execute with a valid/ready handshake.
- Supports a jump redirect and a halt.

---
 rtl/instr_fetch.sv | 92 +++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one word read at a time over req/ack and holds the word for execute.
// Accept at edge k gives mem_req in cycle k+1 and instr_valid from k+2 with zero-wait memory; instr_ready low freezes the word and fetch.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_en,
  input  logic [15:0] jump_addr,
  input  logic        halt_req,
  output logic [15:0] pc,
  output logic        halted
);

  localparam logic [1:0] START  = 2'd0;
  localparam logic [1:0] FETCH  = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0]  state;
  logic        accept;
  logic [15:0] pc_inc;

  assign accept = instr_valid & instr_ready;
  assign pc_inc = pc + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= START;
      pc          <= RESET_PC;
      mem_addr    <= RESET_PC;
      mem_req     <= 1'b0;
      instruction <= 16'h0000;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      case (state)
        START: begin
          mem_req  <= 1'b1;
          mem_addr <= pc;
          state    <= FETCH;
        end
        FETCH: begin
          // Address stays put across wait states; jump/halt only matter on accept.
          if (mem_ack) begin
            instruction <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            pc          <= pc_inc;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            instr_valid <= 1'b0;
            if (halt_req) begin
              halted <= 1'b1;
              if (jump_en) begin
                pc <= jump_addr;
              end
              state <= HALTED;
            end else if (jump_en) begin
              pc       <= jump_addr;
              mem_addr <= jump_addr;
              mem_req  <= 1'b1;
              state    <= FETCH;
            end else begin
              mem_addr <= pc;
              mem_req  <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALTED: begin
          // Terminal until reset.
          state <= HALTED;
        end
        default: begin
          state <= START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: reference memory model with scoreboard, cycle table after reset, then corner-case sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_ack, instr_valid, instr_ready, jump_en, halt_req, halted;
  logic [15:0] mem_addr, mem_rdata, instruction, jump_addr, pc;
  logic        w_mem_req, w_mem_ack, w_instr_valid, w_halted;
  logic [15:0] w_mem_addr, w_mem_rdata, w_instruction, w_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .jump_en(jump_en),
    .jump_addr(jump_addr), .halt_req(halt_req), .pc(pc), .halted(halted)
  );

  instr_fetch #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .instruction(w_instruction),
    .instr_valid(w_instr_valid), .instr_ready(1'b1), .jump_en(1'b0),
    .jump_addr(16'h0000), .halt_req(1'b0), .pc(w_pc), .halted(w_halted)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] exp_q[$];
  int          wait_cfg = 0;
  int          req_cnt  = 0;
  logic [15:0] req_addr = 16'h0000;
  logic        glitch   = 1'b0;
  logic        prev_valid = 1'b0;
  logic [15:0] prev_instr = 16'h0000;

  typedef struct {
    logic        rdy;
    logic        req;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] ins;
    logic [15:0] pcv;
    logic        w_req;
    logic [15:0] w_addr;
    logic [15:0] w_pcv;
    logic [15:0] w_ins;
  } vec_t;

  vec_t vt[6];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h0101;
      16'h0001: return 16'h0184;
      16'h0002: return 16'h0148;
      16'h0003: return 16'h0112;
      default:  return a ^ 16'h6A00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, want 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: sample at negedge, score new words, then drive the memory models for the next edge.
  task automatic step();
    logic [15:0] e;
    @(negedge clk);
    if (instr_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_underflow: got word 0x%04h, want none pending", instruction);
      end else begin
        e = exp_q.pop_front();
        chk("sb_instr", instruction, e);
      end
    end
    if (instr_valid && prev_valid) chk("instr_hold", instruction, prev_instr);
    if (instr_valid) chk("no_prefetch", {15'd0, mem_req}, 16'd0);
    prev_valid = instr_valid;
    prev_instr = instruction;
    if (mem_req) begin
      if (req_cnt == 0) req_addr = mem_addr;
      else chk("addr_stable", mem_addr, req_addr);
      if (req_cnt >= wait_cfg) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        exp_q.push_back(mem_rdata);
        req_cnt   = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'hDEAD;
        req_cnt++;
      end
    end else begin
      req_cnt   = 0;
      mem_ack   = glitch;
      mem_rdata = 16'hBAD0;
    end
    w_mem_ack   = w_mem_req;
    w_mem_rdata = w_mem_addr ^ 16'hC3C3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    w_mem_ack = 1'b0; w_mem_rdata = 16'h0000;
    instr_ready = 1'b1; jump_en = 1'b0; jump_addr = 16'h0000; halt_req = 1'b0;

    //            rdy   req   addr      vld   ins       pc        w_req w_addr    w_pc      w_ins
    vt[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 16'h0000, 1'b1, 16'h0101, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 16'h3C3C};
    vt[2] = '{1'b1, 1'b1, 16'h0001, 1'b0, 16'h0101, 16'h0001, 1'b1, 16'h0000, 16'h0000, 16'h3C3C};
    vt[3] = '{1'b1, 1'b0, 16'h0001, 1'b1, 16'h0184, 16'h0002, 1'b0, 16'h0000, 16'h0001, 16'hC3C3};
    vt[4] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0184, 16'h0002, 1'b1, 16'h0001, 16'h0001, 16'hC3C3};
    vt[5] = '{1'b0, 1'b0, 16'h0002, 1'b1, 16'h0148, 16'h0003, 1'b0, 16'h0001, 16'h0002, 16'hC3C2};

    step();
    step();
    chk("rst_req",    {15'd0, mem_req}, 16'd0);
    chk("rst_addr",   mem_addr, 16'h0000);
    chk("rst_pc",     pc, 16'h0000);
    chk("rst_instr",  instruction, 16'h0000);
    chk("rst_valid",  {15'd0, instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_w_pc",   w_pc, 16'hFFFF);
    chk("rst_w_addr", w_mem_addr, 16'hFFFF);
    rst_n = 1'b1;

    // Zero-wait fetch of three words, plus the wrapping instance alongside.
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("v%0d_req", i),    {15'd0, mem_req}, {15'd0, vt[i].req});
      chk($sformatf("v%0d_addr", i),   mem_addr, vt[i].addr);
      chk($sformatf("v%0d_vld", i),    {15'd0, instr_valid}, {15'd0, vt[i].vld});
      chk($sformatf("v%0d_ins", i),    instruction, vt[i].ins);
      chk($sformatf("v%0d_pc", i),     pc, vt[i].pcv);
      chk($sformatf("v%0d_w_req", i),  {15'd0, w_mem_req}, {15'd0, vt[i].w_req});
      chk($sformatf("v%0d_w_addr", i), w_mem_addr, vt[i].w_addr);
      chk($sformatf("v%0d_w_pc", i),   w_pc, vt[i].w_pcv);
      chk($sformatf("v%0d_w_ins", i),  w_instruction, vt[i].w_ins);
      instr_ready = vt[i].rdy;
    end

    // Backpressure on 0x0112 with a stray ack while no request is out.
    instr_ready = 1'b1;
    step();
    chk("bp_fetch_addr", mem_addr, 16'h0003);
    instr_ready = 1'b0;
    step();
    chk("bp_instr", instruction, 16'h0112);
    chk("bp_pc", pc, 16'h0004);
    for (int i = 0; i < 5; i++) begin
      glitch = (i == 1 || i == 2);
      step();
      chk("bp_hold_vld", {15'd0, instr_valid}, 16'd1);
      chk("bp_hold_ins", instruction, 16'h0112);
      chk("bp_hold_req", {15'd0, mem_req}, 16'd0);
    end
    glitch = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("bp_next_req",  {15'd0, mem_req}, 16'd1);
    chk("bp_next_addr", mem_addr, 16'h0004);

    // Three wait states on address 0x0005.
    step();
    chk("ws_pre_pc", pc, 16'h0005);
    wait_cfg = 3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("ws%0d_req", i),  {15'd0, mem_req}, 16'd1);
      chk($sformatf("ws%0d_addr", i), mem_addr, 16'h0005);
      chk($sformatf("ws%0d_vld", i),  {15'd0, instr_valid}, 16'd0);
    end
    wait_cfg = 0;
    step();
    chk("ws_vld", {15'd0, instr_valid}, 16'd1);
    chk("ws_pc",  pc, 16'h0006);

    // Jump on accept, then jump/halt pulsed during FETCH are ignored.
    jump_en = 1'b1; jump_addr = 16'h0100; wait_cfg = 2;
    step();
    chk("jmp_req",  {15'd0, mem_req}, 16'd1);
    chk("jmp_addr", mem_addr, 16'h0100);
    chk("jmp_pc",   pc, 16'h0100);
    jump_addr = 16'h0BAD; halt_req = 1'b1;
    step();
    chk("jmp_fetch_addr", mem_addr, 16'h0100);
    chk("jmp_fetch_pc",   pc, 16'h0100);
    jump_en = 1'b0; halt_req = 1'b0;
    step();
    chk("jmp_fetch_addr2", mem_addr, 16'h0100);
    wait_cfg = 0;
    step();
    chk("jmp_vld",    {15'd0, instr_valid}, 16'd1);
    chk("jmp_pc_inc", pc, 16'h0101);
    chk("jmp_halted", {15'd0, halted}, 16'd0);

    // Halt wins over jump, pc still takes jump_addr; inputs ignored afterwards.
    halt_req = 1'b1; jump_en = 1'b1; jump_addr = 16'h0222;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("hlt%0d_halted", i), {15'd0, halted}, 16'd1);
      chk($sformatf("hlt%0d_req", i),    {15'd0, mem_req}, 16'd0);
      chk($sformatf("hlt%0d_vld", i),    {15'd0, instr_valid}, 16'd0);
      chk($sformatf("hlt%0d_pc", i),     pc, 16'h0222);
      chk($sformatf("hlt%0d_ins", i),    instruction, 16'h6B00);
      halt_req = 1'b0;
      jump_en = (i % 2 == 0);
      jump_addr = 16'h0777;
      glitch = (i == 3 || i == 4);
      instr_ready = (i % 3 != 0);
    end
    glitch = 1'b0; jump_en = 1'b0; instr_ready = 1'b1;

    // Reset out of HALTED, then pulse reset mid-cycle with an ack in flight.
    rst_n = 1'b0;
    step();
    chk("rr_halted", {15'd0, halted}, 16'd0);
    chk("rr_pc",     pc, 16'h0000);
    exp_q.delete(); req_cnt = 0; wait_cfg = 1;
    rst_n = 1'b1;
    step();
    chk("rr_fetch_req",  {15'd0, mem_req}, 16'd1);
    chk("rr_fetch_addr", mem_addr, 16'h0000);
    step();
    chk("rr_ack_driven", {15'd0, mem_ack}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_async_req", {15'd0, mem_req}, 16'd0);
    chk("rr_async_pc",  pc, 16'h0000);
    #1 rst_n = 1'b1;
    exp_q.delete(); req_cnt = 0; wait_cfg = 0;
    step();
    chk("rr_restart_req",  {15'd0, mem_req}, 16'd1);
    chk("rr_restart_addr", mem_addr, 16'h0000);
    chk("rr_discard_vld",  {15'd0, instr_valid}, 16'd0);
    chk("rr_discard_ins",  instruction, 16'h0000);
    step();
    chk("rr_resume_vld", {15'd0, instr_valid}, 16'd1);
    chk("rr_resume_ins", instruction, 16'h0101);
    chk("rr_resume_pc",  pc, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
